// File: rtl/drac_pkg.sv
// Shared core types for the return-address-stack command path.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Build option: RAS_COMPRESSED_EN adds a per-command compressed flag to ras_cmd_t.
package drac_pkg;

    localparam int PHY_VIRT_MAX_ADDR_SIZE = 40;
    typedef logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] addrPC_t;

    // log2 of the number of RAS entries, shared with the return address stack
    localparam int LENGTH_RAS = 4;

    localparam logic [4:0] RAS_LINK_REG_X1 = 5'd1;
    localparam logic [4:0] RAS_LINK_REG_X5 = 5'd5;

    // addr carries the jump PC; the link address is formed at the FIFO head
    typedef struct packed {
        logic    push;
        logic    pop;
        addrPC_t addr;
`ifdef RAS_COMPRESSED_EN
        logic    compressed;
`endif
    } ras_cmd_t;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == RAS_LINK_REG_X1) || (r == RAS_LINK_REG_X5);
    endfunction

endpackage

// File: rtl/ras_cmd_fifo.sv
// Command FIFO of ras_cmd_t entries with flush.
// Latency: a written entry is visible at rd_dat_o the cycle after the write.
// Backpressure: writes are ignored when full; flush drops all entries and suppresses that cycle's write and read.
// Ports: clk_i/rst_i (sync, active-high), flush_i, wr_en_i/wr_dat_i, rd_en_i/rd_dat_o,
//        full_o, empty_o, count_o (0..QUEUE_DEPTH).
module ras_cmd_fifo
    import drac_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  ras_cmd_t                     wr_dat_i,
    input  logic                         rd_en_i,
    output ras_cmd_t                     rd_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(QUEUE_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QUEUE_DEPTH);

    ras_cmd_t         r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

    assign w_do_wr = wr_en_i && !full_o  && !flush_i;
    assign w_do_rd = rd_en_i && !empty_o && !flush_i;

    // Storage is cleared on reset so the head reads as an empty command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= wr_dat_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_dat_o = r_mem[r_rd_ptr];

endmodule

// File: rtl/ras_update_ctrl.sv
// Classifies resolved JAL/JALR into RAS push/pop commands, queues them and issues one per cycle.
// Latency: command accepted in cycle N issues in cycle N+1 when the queue was empty and hold_i is low.
// Backpressure: ready_o drops when the queue is full; hold_i stalls issue; flush_i empties the queue.
// Ports: clk_i/rst_i (sync, active-high); valid_i/ready_o, pc_i, is_jal_i, is_jalr_i, rd_i, rs1_i in;
//        flush_i, hold_i control; push_o, pop_o, pc_push_o to the RAS; depth_o, underflow_o to perf counters.
// Build option: RAS_COMPRESSED_EN adds is_compressed_i (link = pc+2 for compressed jumps).
module ras_update_ctrl
    import drac_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int LENGTH_RAS  = drac_pkg::LENGTH_RAS
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] pc_i,
    input  logic                              is_jal_i,
    input  logic                              is_jalr_i,
    input  logic [4:0]                        rd_i,
    input  logic [4:0]                        rs1_i,
`ifdef RAS_COMPRESSED_EN
    input  logic                              is_compressed_i,
`endif
    input  logic                              flush_i,
    input  logic                              hold_i,
    output logic                              push_o,
    output logic                              pop_o,
    output logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] pc_push_o,
    output logic [LENGTH_RAS:0]               depth_o,
    output logic                              underflow_o
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(QUEUE_DEPTH);
    localparam logic [LENGTH_RAS:0] DEPTH_MAX = (LENGTH_RAS+1)'(2**LENGTH_RAS);

    ras_cmd_t         w_cmd;
    ras_cmd_t         w_head;
    logic             w_rd_link;
    logic             w_rs1_link;
    logic             w_cmd_vld;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_issue;
    addrPC_t          w_link_inc;

    logic [LENGTH_RAS:0] r_depth;
    logic                r_underflow;

    // ---------------- classification ----------------
    assign w_rd_link  = is_link_reg(rd_i);
    assign w_rs1_link = is_link_reg(rs1_i);

    always_comb begin
        w_cmd      = '0;
        w_cmd.addr = pc_i;
`ifdef RAS_COMPRESSED_EN
        w_cmd.compressed = is_compressed_i;
`endif
        if (is_jal_i) begin
            w_cmd.push = w_rd_link;
        end else if (is_jalr_i) begin
            w_cmd.push = w_rd_link;
            // same link register in rd and rs1 is a plain call, not a coroutine swap
            w_cmd.pop  = w_rs1_link && (!w_rd_link || (rd_i != rs1_i));
        end
    end

    assign w_cmd_vld = w_cmd.push || w_cmd.pop;

    // ---------------- command queue ----------------
    // ready_o looks only at occupancy so it never depends on this cycle's issue.
    assign ready_o = (w_count != FULL_CNT);
    assign w_issue = !w_empty && !hold_i && !flush_i;

    ras_cmd_fifo #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .wr_en_i  (valid_i && w_cmd_vld && !w_full),
        .wr_dat_i (w_cmd),
        .rd_en_i  (w_issue),
        .rd_dat_o (w_head),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .count_o  (w_count)
    );

    // ---------------- issue ----------------
`ifdef RAS_COMPRESSED_EN
    assign w_link_inc = w_head.compressed ? addrPC_t'(2) : addrPC_t'(4);
`else
    assign w_link_inc = addrPC_t'(4);
`endif

    assign push_o = w_issue && w_head.push;
    assign pop_o  = w_issue && w_head.pop;
    // A never-written slot holds an all-zero command and shows address 0.
    assign pc_push_o = (w_head.push || w_head.pop) ? (w_head.addr + w_link_inc) : '0;

    // ---------------- shadow depth ----------------
    // Not touched by flush: the RAS itself keeps its contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_depth     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= 1'b0;
            if (w_issue) begin
                if (w_head.push && !w_head.pop) begin
                    if (r_depth != DEPTH_MAX) begin
                        r_depth <= r_depth + 1'b1;
                    end
                end else if (w_head.pop && !w_head.push) begin
                    if (r_depth == '0) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_depth <= r_depth - 1'b1;
                    end
                end
            end
        end
    end

    assign depth_o     = r_depth;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_ras_update_ctrl.sv
// Self-checking bench for ras_update_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a queue-based reference model.
module tb_ras_update_ctrl;

    localparam int QD   = 4;
    localparam int LR   = 4;
    localparam int DMAX = 2**LR;
`ifdef RAS_COMPRESSED_EN
    localparam bit COMP_EN = 1'b1;
`else
    localparam bit COMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [39:0] pc = '0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic        is_comp = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        push;
    logic        pop;
    logic [39:0] pc_push;
    logic [LR:0] depth;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ras_update_ctrl #(.QUEUE_DEPTH(QD), .LENGTH_RAS(LR)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .ready_o     (ready),
        .pc_i        (pc),
        .is_jal_i    (is_jal),
        .is_jalr_i   (is_jalr),
        .rd_i        (rd),
        .rs1_i       (rs1),
`ifdef RAS_COMPRESSED_EN
        .is_compressed_i (is_comp),
`endif
        .flush_i     (flush),
        .hold_i      (hold),
        .push_o      (push),
        .pop_o       (pop),
        .pc_push_o   (pc_push),
        .depth_o     (depth),
        .underflow_o (underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          pu;
        bit          po;
        logic [39:0] link;
    } mcmd_t;

    mcmd_t mq[$];
    int    mdepth = 0;
    bit    mund = 1'b0;
    bit    model_ok = 1'b0;

    function automatic mcmd_t classify(input bit jal, input bit jalr, input logic [4:0] d,
                                       input logic [4:0] s, input logic [39:0] p, input bit c);
        mcmd_t m;
        bit ld = (d == 5'd1) || (d == 5'd5);
        bit ls = (s == 5'd1) || (s == 5'd5);
        m.pu = 1'b0;
        m.po = 1'b0;
        m.link = p + ((COMP_EN && c) ? 40'd2 : 40'd4);
        if (jal) begin
            m.pu = ld;
        end else if (jalr) begin
            if (!ld && ls)      m.po = 1'b1;
            else if (ld && !ls) m.pu = 1'b1;
            else if (ld && ls) begin
                m.pu = 1'b1;
                m.po = (d != s);
            end
        end
        return m;
    endfunction

    // Compare on the falling edge (inputs stable), then advance the model to the next cycle.
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit    issue;
                bit    rdy;
                mcmd_t nc;
                rdy   = (mq.size() < QD);
                issue = (mq.size() > 0) && !hold && !flush;
                if (model_ok) begin
                    chk("model_ready", ready, rdy);
                    chk("model_push", push, issue ? mq[0].pu : 1'b0);
                    chk("model_pop", pop, issue ? mq[0].po : 1'b0);
                    if (issue) chk("model_pc_push", pc_push, mq[0].link);
                    chk("model_depth", depth, mdepth);
                    chk("model_underflow", underflow, mund);
                end
                if (rst) begin
                    mq.delete();
                    mdepth   = 0;
                    mund     = 1'b0;
                    model_ok = 1'b1;
                end else begin
                    mund = 1'b0;
                    nc = classify(is_jal, is_jalr, rd, rs1, pc, is_comp);
                    if (issue) begin
                        if (mq[0].pu && !mq[0].po) begin
                            if (mdepth < DMAX) mdepth++;
                        end else if (mq[0].po && !mq[0].pu) begin
                            if (mdepth == 0) mund = 1'b1;
                            else mdepth--;
                        end
                    end
                    if (flush) begin
                        mq.delete();
                    end else begin
                        if (issue) void'(mq.pop_front());
                        if (valid && rdy && (nc.pu || nc.po)) mq.push_back(nc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        rd = '0; rs1 = '0; pc = '0; is_comp = 1'b0;
    endtask

    task automatic jump(input bit jal, input logic [4:0] d, input logic [4:0] s,
                        input logic [39:0] p, input bit c);
        valid = 1'b1; is_jal = jal; is_jalr = !jal;
        rd = d; rs1 = s; pc = p; is_comp = c;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        next(); next();
        rst = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_pc_push", pc_push, 0);
        chk("rst_depth", depth, 0);
        chk("rst_underflow", underflow, 0);
        next();

        // call
        jump(1, 5'd1, 5'd0, 40'h1000, 0);
        @(negedge clk); chk("call_no_same_cycle", push, 0);
        next(); idle();
        @(negedge clk);
        chk("call_push", push, 1); chk("call_pop", pop, 0); chk("call_pc", pc_push, 40'h1004);
        next();
        @(negedge clk); chk("call_depth", depth, 1);
        next();

        // return
        jump(0, 5'd0, 5'd1, 40'h1100, 0);
        next(); idle();
        @(negedge clk); chk("ret_pop", pop, 1); chk("ret_push", push, 0);
        next();
        @(negedge clk); chk("ret_depth", depth, 0); chk("ret_no_uf", underflow, 0);
        next();

        // return at depth 0 -> underflow pulse
        jump(0, 5'd0, 5'd1, 40'h1100, 0);
        next(); idle();
        @(negedge clk); chk("uf_pop", pop, 1);
        next();
        @(negedge clk); chk("uf_pulse", underflow, 1); chk("uf_depth", depth, 0);
        next();
        @(negedge clk); chk("uf_one_cycle", underflow, 0);
        next();

        // coroutine swap
        jump(0, 5'd1, 5'd5, 40'h2000, 0);
        next(); idle();
        @(negedge clk);
        chk("swap_push", push, 1); chk("swap_pop", pop, 1); chk("swap_pc", pc_push, 40'h2004);
        next();
        @(negedge clk); chk("swap_depth", depth, 0);
        next();

        // backpressure
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            jump(1, 5'd5, 5'd0, 40'(i * 'h100), 0);
            @(negedge clk); chk("bp_ready_fill", ready, 1);
            next();
        end
        jump(1, 5'd5, 5'd0, 40'h500, 0);
        @(negedge clk); chk("bp_full", ready, 0); chk("bp_hold_push", push, 0);
        next();
        hold = 1'b0;
        @(negedge clk); chk("bp_full_during_issue", ready, 0);
        chk("bp_push0", push, 1); chk("bp_pc0", pc_push, 40'h104);
        next();
        @(negedge clk); chk("bp_ready_again", ready, 1); chk("bp_pc1", pc_push, 40'h204);
        next(); idle();
        @(negedge clk); chk("bp_pc2", pc_push, 40'h304);
        next();
        @(negedge clk); chk("bp_pc3", pc_push, 40'h404);
        next();
        @(negedge clk); chk("bp_push4", push, 1); chk("bp_pc4", pc_push, 40'h504);
        next();
        @(negedge clk); chk("bp_drained", push, 0); chk("bp_depth", depth, 5);
        next();

        // flush
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            jump(1, 5'd1, 5'd0, 40'h600 + 40'(i * 'h100), 0);
            next();
        end
        jump(1, 5'd1, 5'd0, 40'h900, 0);
        flush = 1'b1;
        @(negedge clk); chk("flush_cycle_push", push, 0);
        next();
        flush = 1'b0; hold = 1'b0; idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_push", push, 0); chk("flush_ready", ready, 1); chk("flush_depth", depth, 5);
            next();
        end

        // non-link jumps
        jump(1, 5'd0, 5'd0, 40'hA00, 0);
        next();
        jump(0, 5'd0, 5'd2, 40'hB00, 0);
        next(); idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("nolink_push", push, 0); chk("nolink_pop", pop, 0);
            next();
        end

        // depth saturation
        for (int i = 0; i < 18; i++) begin
            jump(1, 5'd1, 5'd0, 40'hC000 + 40'(i * 8), 0);
            next();
        end
        idle(); next(); next();
        @(negedge clk); chk("sat_depth", depth, DMAX);
        next();

`ifdef RAS_COMPRESSED_EN
        jump(1, 5'd1, 5'd0, 40'h3000, 1);
        next(); idle();
        @(negedge clk); chk("comp_push", push, 1); chk("comp_pc", pc_push, 40'h3002);
        next();
`endif

        // randomized traffic, including address wrap and mid-run reset
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] regs [6];
            regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5;
            regs[3] = 5'd2; regs[4] = 5'd1; regs[5] = 5'($urandom);
            valid   = ($urandom_range(0, 99) < 70);
            is_jal  = $urandom_range(0, 1);
            is_jalr = !is_jal && ($urandom_range(0, 9) < 8);
            rd      = regs[$urandom_range(0, 5)];
            rs1     = regs[$urandom_range(0, 5)];
            pc      = ($urandom_range(0, 9) == 0) ? (40'hFF_FFFF_FFFE - 40'($urandom_range(0, 3)))
                                                  : {8'($urandom), 32'($urandom)};
            is_comp = $urandom_range(0, 1);
            hold    = ($urandom_range(0, 99) < 30);
            flush   = ($urandom_range(0, 99) < 4);
            rst     = ($urandom_range(0, 999) < 3);
            next();
        end
        rst = 1'b0; flush = 1'b0; hold = 1'b0; idle();
        next(); next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
